sf3_page_test_sequencer: RTL and testbench
==========================================

// Module: sf3_page_test_sequencer
// PURPOSE
// - Command source for pmod_sf3_custom_driver: one erase-subsector, page-program, read-back, compare pass per i_start.
// - Drives the driver's command, write-stream and read-stream ports.
// - Reports pass/fail, error count and first mismatch index to the tester top level.
// PARAMETERS
// parm_page_len   256    bytes per program/read; legal range 1..256
// parm_lfsr_seed  8'hA5  pattern LFSR seed; a value of 0 is replaced by 8'h01
// PORTS
// i_clk_mhz             in   1   system clock; same clock as the driver
// i_rstn_mhz            in   1   asynchronous, active-low reset
// i_ce_mhz_div          in   1   clock enable; all state advances only when this is 1
// i_start               in   1   begin a test pass; sampled in IDLE only
// i_test_address        in   32  flash byte address of the pass
// o_busy                out  1   1 from leaving IDLE until DONE completes
// o_done                out  1   one CE-cycle pulse at the end of a pass
// o_pass                out  1   1 when the last pass had zero mismatches
// o_err_count           out  9   mismatch count of the last pass; saturates at 256
// o_first_err_idx       out  9   byte index of the first mismatch; 9'h1FF if none
// i_command_ready       in   1   driver idle and accepting a command
// o_address_of_cmd      out  32  command address
// o_cmd_erase_subsector out  1   one CE-cycle command strobe
// o_cmd_page_program    out  1   one CE-cycle command strobe
// o_cmd_random_read     out  1   one CE-cycle command strobe
// o_len_random_read     out  9   parm_page_len
// o_wr_data_stream      out  8   pattern byte
// o_wr_data_valid       out  1   write-stream valid
// i_wr_data_ready       in   1   write-stream ready
// i_rd_data_stream      in   8   read-back byte
// i_rd_data_valid       in   1   read-back strobe; one byte per CE cycle when 1
// BEHAVIOUR
// - Reset: FSM=IDLE; all strobes, valid, o_busy, o_done and o_pass are 0; counters are 0; o_first_err_idx=9'h1FF.
// - Reset asserted mid-pass aborts the pass at once; no strobe or valid may remain high.
// - Addresses:
//   - Erase uses {i_test_address[31:12],12'h000}.
//   - Program and read use {i_test_address[31:8],8'h00}.
//   - The address is latched on start.
// - Pattern: 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1.
//   - Loaded with the seed when entering PROG_DATA and again when entering READ_DATA.
//   - Shifts once per byte transferred (written or compared).
// - Command handshake:
//   - A strobe is issued for one CE cycle, only while i_command_ready=1.
//   - FSM then waits for i_command_ready=0, the acceptance acknowledgement.
//   - It then waits for i_command_ready=1, meaning the command has completed.
// - FSM states and transitions:
//   - IDLE -> ERASE_CMD on i_start&ce. Latch the address, clear the counters, o_busy<=1.
//   - ERASE_CMD -> ERASE_ACK -> ERASE_WAIT: runs the handshake above.
//   - PROG_DATA: o_wr_data_valid=1.
//     - On valid&ready&ce: byte count +1, LFSR steps.
//     - At count==parm_page_len go to PROG_CMD. Valid must drop in the same cycle.
//     - Valid never drops before a transfer.
//   - PROG_CMD -> PROG_ACK -> PROG_WAIT: runs the handshake.
//   - READ_CMD -> READ_ACK -> READ_DATA: runs the handshake. READ_DATA is entered as soon as the command is accepted.
//   - READ_DATA: on rd_valid&ce, compare i_rd_data_stream with the LFSR.
//     - On mismatch: err +1 (saturating); record the index if it is the first.
//     - At count==parm_page_len and i_command_ready=1, go to DONE.
//     - Bytes beyond the length are ignored.
//   - DONE: o_done=1 for one CE cycle; o_pass<=(err==0); o_busy<=0; -> IDLE.
// - Result hold: o_pass, o_err_count and o_first_err_idx hold until the next accepted i_start, which clears them.
// - i_start while busy is ignored; no queueing.
// - A read byte arriving in the same cycle that the count reaches the length is counted and compared.
// - Widths: the byte counter is 9 bits and counts 0..256 without wrap; the error counter saturates at 9'd256.
// STRUCTURE
// - Package sf3_tester_pkg:
//   - t_seq_state enum.
//   - c_sf3_subsector_mask and c_sf3_page_mask.
//   - c_lfsr_taps.
//   - function lfsr_next(logic [7:0]).
// - One sub-module, sf3_pattern_lfsr: load, step and seed inputs; 8-bit output. The same instance serves both write and compare.
// - No other sub-modules. All outputs are registered.
// TESTING
// 1. Driver BFM that echoes written bytes. Start at 0x0001_2345.
//    - Erase address 0x0001_2000; program and read address 0x0001_2300.
//    - 256 bytes written; o_pass=1, o_err_count=0, o_first_err_idx=0x1FF.
// 2. BFM corrupts read bytes 5 and 200 (bit 0 flipped).
//    - o_pass=0, o_err_count=2, o_first_err_idx=5.
// 3. BFM randomly deasserts i_wr_data_ready (50%) and i_rd_data_valid.
//    - Exactly 256 writes; pattern order identical to test 1; pass.
// 4. i_start pulsed again during PROG_DATA -> ignored; a single o_done.
//    - i_ce_mhz_div=1 one cycle in four: the result matches test 1.
// 5. i_rstn_mhz low during READ_DATA.
//    - All strobes and valid are 0 immediately; o_busy=0.
//    - A subsequent start completes with a pass.
// 6. BFM returns all 0xFF (erase only).
//    - o_err_count equals the count of LFSR bytes != 0xFF.
//    - Saturation check: with parm_page_len=256 and all bytes wrong, o_err_count=256.

Source files
------------

// File: rtl/sf3_tester_pkg.sv
// Shared types and constants for the SF3 page test sequencer: FSM states,
// flash address masks and the pattern LFSR step function.
package sf3_tester_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ERASE_CMD,
        S_ERASE_ACK,
        S_ERASE_WAIT,
        S_PROG_DATA,
        S_PROG_CMD,
        S_PROG_ACK,
        S_PROG_WAIT,
        S_READ_CMD,
        S_READ_ACK,
        S_READ_DATA,
        S_DONE
    } t_seq_state;

    localparam logic [31:0] c_sf3_subsector_mask = 32'hFFFF_F000;
    localparam logic [31:0] c_sf3_page_mask      = 32'hFFFF_FF00;

    // x^8+x^6+x^5+x^4+1 as a left-shifting Fibonacci register: taps on bits 7,5,4,3
    localparam logic [7:0]  c_lfsr_taps  = 8'hB8;
    localparam logic [8:0]  c_no_err_idx = 9'h1FF;
    localparam logic [8:0]  c_err_sat    = 9'd256;

    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], ^(q & c_lfsr_taps)};
    endfunction

endpackage

// File: rtl/sf3_pattern_lfsr.sv
// Pattern generator shared by the write and compare phases; updates one CE cycle
// after load/step, never stalls (the caller gates step with its own handshake).
module sf3_pattern_lfsr
    import sf3_tester_pkg::*;
(
    input  logic       i_clk_mhz,
    input  logic       i_rstn_mhz,
    input  logic       i_ce_mhz_div,
    input  logic       i_load,
    input  logic       i_step,
    input  logic [7:0] i_seed,
    output logic [7:0] o_pattern
);

    always_ff @(posedge i_clk_mhz or negedge i_rstn_mhz) begin
        if (!i_rstn_mhz) begin
            o_pattern <= 8'h01;
        end else if (i_ce_mhz_div) begin
            if (i_load) begin
                o_pattern <= i_seed;
            end else if (i_step) begin
                o_pattern <= lfsr_next(o_pattern);
            end
        end
    end

endmodule

// File: rtl/sf3_page_test_sequencer.sv
// Erase / program / read-back / compare of one flash page per start; all outputs
// registered, one CE cycle behind the FSM; waits indefinitely on driver ready/valid.
module sf3_page_test_sequencer
    import sf3_tester_pkg::*;
#(
    parameter int         parm_page_len  = 256,
    parameter logic [7:0] parm_lfsr_seed = 8'hA5
) (
    input  logic        i_clk_mhz,
    input  logic        i_rstn_mhz,
    input  logic        i_ce_mhz_div,
    input  logic        i_start,
    input  logic [31:0] i_test_address,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_pass,
    output logic [8:0]  o_err_count,
    output logic [8:0]  o_first_err_idx,
    input  logic        i_command_ready,
    output logic [31:0] o_address_of_cmd,
    output logic        o_cmd_erase_subsector,
    output logic        o_cmd_page_program,
    output logic        o_cmd_random_read,
    output logic [8:0]  o_len_random_read,
    output logic [7:0]  o_wr_data_stream,
    output logic        o_wr_data_valid,
    input  logic        i_wr_data_ready,
    input  logic [7:0]  i_rd_data_stream,
    input  logic        i_rd_data_valid
);

    localparam logic [8:0] c_len  = 9'(parm_page_len);
    localparam logic [7:0] c_seed = (parm_lfsr_seed == 8'h00) ? 8'h01 : parm_lfsr_seed;

    t_seq_state  state, state_nxt;
    logic [31:0] addr_q;
    logic [8:0]  byte_cnt;
    logic [8:0]  cnt_inc;
    logic [7:0]  pattern;
    logic        lfsr_load;
    logic        wr_xfer;
    logic        rd_take;
    logic        mismatch;
    logic        start_acc;

    assign cnt_inc           = byte_cnt + 9'd1;
    assign start_acc         = (state == S_IDLE) && i_start;
    assign mismatch          = rd_take && (i_rd_data_stream != pattern);
    assign o_wr_data_stream  = pattern;
    assign o_len_random_read = c_len;

    sf3_pattern_lfsr u_lfsr (
        .i_clk_mhz    (i_clk_mhz),
        .i_rstn_mhz   (i_rstn_mhz),
        .i_ce_mhz_div (i_ce_mhz_div),
        .i_load       (lfsr_load),
        .i_step       (wr_xfer || rd_take),
        .i_seed       (c_seed),
        .o_pattern    (pattern)
    );

    always_ff @(posedge i_clk_mhz or negedge i_rstn_mhz) begin
        if (!i_rstn_mhz) begin
            state <= S_IDLE;
        end else if (i_ce_mhz_div) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        lfsr_load = 1'b0;
        wr_xfer   = 1'b0;
        rd_take   = 1'b0;
        case (state)
            S_IDLE:       if (i_start)          state_nxt = S_ERASE_CMD;
            S_ERASE_CMD:  if (i_command_ready)  state_nxt = S_ERASE_ACK;
            S_ERASE_ACK:  if (!i_command_ready) state_nxt = S_ERASE_WAIT;
            S_ERASE_WAIT: if (i_command_ready) begin
                state_nxt = S_PROG_DATA;
                lfsr_load = 1'b1;
            end
            S_PROG_DATA: begin
                wr_xfer = i_wr_data_ready;
                if (i_wr_data_ready && (cnt_inc == c_len)) state_nxt = S_PROG_CMD;
            end
            S_PROG_CMD:   if (i_command_ready)  state_nxt = S_PROG_ACK;
            S_PROG_ACK:   if (!i_command_ready) state_nxt = S_PROG_WAIT;
            S_PROG_WAIT:  if (i_command_ready)  state_nxt = S_READ_CMD;
            S_READ_CMD:   if (i_command_ready)  state_nxt = S_READ_ACK;
            S_READ_ACK:   if (!i_command_ready) begin
                state_nxt = S_READ_DATA;
                lfsr_load = 1'b1;
            end
            S_READ_DATA: begin
                // surplus bytes after the page are neither counted nor compared
                rd_take = i_rd_data_valid && (byte_cnt != c_len);
                if ((byte_cnt == c_len) && i_command_ready) state_nxt = S_DONE;
            end
            S_DONE:       state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk_mhz or negedge i_rstn_mhz) begin
        if (!i_rstn_mhz) begin
            addr_q                <= '0;
            byte_cnt              <= '0;
            o_busy                <= 1'b0;
            o_done                <= 1'b0;
            o_pass                <= 1'b0;
            o_err_count           <= '0;
            o_first_err_idx       <= c_no_err_idx;
            o_address_of_cmd      <= '0;
            o_cmd_erase_subsector <= 1'b0;
            o_cmd_page_program    <= 1'b0;
            o_cmd_random_read     <= 1'b0;
            o_wr_data_valid       <= 1'b0;
        end else if (i_ce_mhz_div) begin
            // strobes last exactly the CE cycle in which the driver reported ready
            o_cmd_erase_subsector <= (state == S_ERASE_CMD) && i_command_ready;
            o_cmd_page_program    <= (state == S_PROG_CMD)  && i_command_ready;
            o_cmd_random_read     <= (state == S_READ_CMD)  && i_command_ready;
            o_wr_data_valid       <= (state_nxt == S_PROG_DATA);
            o_done                <= (state_nxt == S_DONE);

            if (start_acc) begin
                addr_q           <= i_test_address & c_sf3_page_mask;
                o_address_of_cmd <= i_test_address & c_sf3_subsector_mask;
                o_busy           <= 1'b1;
                o_pass           <= 1'b0;
                o_err_count      <= '0;
                o_first_err_idx  <= c_no_err_idx;
            end
            if ((state == S_ERASE_WAIT) && i_command_ready) begin
                o_address_of_cmd <= addr_q;
            end

            if (start_acc || lfsr_load) begin
                byte_cnt <= '0;
            end else if (wr_xfer || rd_take) begin
                byte_cnt <= cnt_inc;
            end

            if (mismatch) begin
                if (o_err_count != c_err_sat) o_err_count <= o_err_count + 9'd1;
                if (o_first_err_idx == c_no_err_idx) o_first_err_idx <= byte_cnt;
            end

            // no byte is taken on the exit edge, so the count is already final here
            if ((state == S_READ_DATA) && (state_nxt == S_DONE)) begin
                o_pass <= (o_err_count == 9'd0);
            end
            if (state == S_DONE) begin
                o_busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sf3_page_test_sequencer.sv
// Bench for sf3_page_test_sequencer: a flash-driver model with echo memory,
// write-pattern and per-pass result scoreboards.
module tb_sf3_page_test_sequencer;

    logic        i_clk_mhz;
    logic        i_rstn_mhz;
    logic        i_ce_mhz_div;
    logic        i_start;
    logic [31:0] i_test_address;
    logic        o_busy;
    logic        o_done;
    logic        o_pass;
    logic [8:0]  o_err_count;
    logic [8:0]  o_first_err_idx;
    logic        i_command_ready;
    logic [31:0] o_address_of_cmd;
    logic        o_cmd_erase_subsector;
    logic        o_cmd_page_program;
    logic        o_cmd_random_read;
    logic [8:0]  o_len_random_read;
    logic [7:0]  o_wr_data_stream;
    logic        o_wr_data_valid;
    logic        i_wr_data_ready;
    logic [7:0]  i_rd_data_stream;
    logic        i_rd_data_valid;

    sf3_page_test_sequencer dut (
        .i_clk_mhz             (i_clk_mhz),
        .i_rstn_mhz            (i_rstn_mhz),
        .i_ce_mhz_div          (i_ce_mhz_div),
        .i_start               (i_start),
        .i_test_address        (i_test_address),
        .o_busy                (o_busy),
        .o_done                (o_done),
        .o_pass                (o_pass),
        .o_err_count           (o_err_count),
        .o_first_err_idx       (o_first_err_idx),
        .i_command_ready       (i_command_ready),
        .o_address_of_cmd      (o_address_of_cmd),
        .o_cmd_erase_subsector (o_cmd_erase_subsector),
        .o_cmd_page_program    (o_cmd_page_program),
        .o_cmd_random_read     (o_cmd_random_read),
        .o_len_random_read     (o_len_random_read),
        .o_wr_data_stream      (o_wr_data_stream),
        .o_wr_data_valid       (o_wr_data_valid),
        .i_wr_data_ready       (i_wr_data_ready),
        .i_rd_data_stream      (i_rd_data_stream),
        .i_rd_data_valid       (i_rd_data_valid)
    );

    typedef struct {
        logic pass;
        int   err;
        int   first;
    } res_t;

    typedef enum int {B_IDLE, B_BUSY, B_READ} bfm_t;

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [7:0]  wr_q[$];
    res_t        res_q[$];
    logic [7:0]  mem[256];
    bfm_t        bst;
    int          btimer;
    int          rd_idx;
    int          wr_cnt;
    int          done_cnt;
    int          phase;
    logic [31:0] exp_erase_addr;
    logic [31:0] exp_page_addr;
    logic        slow_ce, rand_mode, corrupt, no_store, invert;
    int          rd_extra;

    initial i_clk_mhz = 1'b0;
    always #5 i_clk_mhz = ~i_clk_mhz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_lfsr(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    function automatic logic [7:0] rd_byte(input int idx);
        logic [7:0] b;
        b = (idx < 256) ? mem[idx] : 8'h00;
        if (corrupt && (idx == 5 || idx == 200)) b = b ^ 8'h01;
        if (invert) b = ~b;
        return b;
    endfunction

    // Driver model: acts only on CE edges; inputs set here are those sampled at the next edge.
    initial begin
        res_t r;
        logic [7:0] e;
        i_ce_mhz_div = 1'b0; i_command_ready = 1'b1; i_wr_data_ready = 1'b0;
        i_rd_data_valid = 1'b0; i_rd_data_stream = 8'h00;
        bst = B_IDLE; btimer = 0; rd_idx = 0; wr_cnt = 0; done_cnt = 0; phase = 0;
        forever begin
            @(negedge i_clk_mhz);
            phase = (phase + 1) % 4;
            i_ce_mhz_div = slow_ce ? (phase == 0) : 1'b1;
            if (!i_rstn_mhz) begin
                bst = B_IDLE;
                i_command_ready = 1'b1;
                i_wr_data_ready = 1'b0;
                i_rd_data_valid = 1'b0;
            end else if (i_ce_mhz_div) begin
                i_command_ready = (bst == B_IDLE);
                i_wr_data_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
                i_rd_data_valid = 1'b0;
                if (bst == B_READ) begin
                    if (btimer > 0) begin
                        btimer--;
                    end else begin
                        i_rd_data_valid  = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
                        i_rd_data_stream = rd_byte(rd_idx);
                    end
                end

                if (o_wr_data_valid && i_wr_data_ready) begin
                    chk("wr_not_overrun", 32'(wr_q.size() != 0), 1);
                    if (wr_q.size() != 0) begin
                        e = wr_q.pop_front();
                        chk("wr_pattern", 32'(o_wr_data_stream), 32'(e));
                    end
                    if (!no_store && wr_cnt < 256) mem[wr_cnt] = o_wr_data_stream;
                    wr_cnt++;
                end

                if (i_rd_data_valid) begin
                    rd_idx++;
                    if (rd_idx == 256 + rd_extra) bst = B_IDLE;
                end

                if (o_cmd_erase_subsector || o_cmd_page_program || o_cmd_random_read) begin
                    chk("strobe_while_ready", 32'(bst == B_IDLE), 1);
                    if (bst == B_IDLE) begin
                        if (o_cmd_erase_subsector) begin
                            chk("erase_addr", o_address_of_cmd, exp_erase_addr);
                            for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
                            bst = B_BUSY; btimer = 3;
                        end else if (o_cmd_page_program) begin
                            chk("prog_addr", o_address_of_cmd, exp_page_addr);
                            bst = B_BUSY; btimer = 3;
                        end else begin
                            chk("read_addr", o_address_of_cmd, exp_page_addr);
                            chk("read_len", 32'(o_len_random_read), 256);
                            bst = B_READ; btimer = 2; rd_idx = 0;
                        end
                    end
                end else if (bst == B_BUSY) begin
                    if (btimer == 0) bst = B_IDLE;
                    else btimer--;
                end

                if (o_done) begin
                    done_cnt++;
                    chk("done_expected", 32'(res_q.size() != 0), 1);
                    if (res_q.size() != 0) begin
                        r = res_q.pop_front();
                        chk("result_pass", 32'(o_pass), 32'(r.pass));
                        chk("result_err_count", 32'(o_err_count), r.err);
                        chk("result_first_idx", 32'(o_first_err_idx), r.first);
                        chk("write_total", wr_cnt, 256);
                    end
                end
            end
        end
    end

    task automatic setup_pass(input logic [31:0] addr, input logic pass, input int err, input int first);
        res_t r;
        logic [7:0] q;
        q = 8'hA5;
        for (int i = 0; i < 256; i++) begin
            wr_q.push_back(q);
            q = m_lfsr(q);
        end
        r.pass = pass; r.err = err; r.first = first;
        res_q.push_back(r);
        wr_cnt = 0;
        rd_idx = 0;
        i_test_address = addr;
        exp_erase_addr = {addr[31:12], 12'h000};
        exp_page_addr  = {addr[31:8], 8'h00};
    endtask

    task automatic do_start();
        @(negedge i_clk_mhz);
        i_start = 1'b1;
        for (int i = 0; i < 64 && !o_busy; i++) @(negedge i_clk_mhz);
        i_start = 1'b0;
        chk("start_busy", 32'(o_busy), 1);
    endtask

    task automatic wait_done(input int d0, input logic exp_pass);
        for (int i = 0; i < 30000 && done_cnt == d0; i++) @(negedge i_clk_mhz);
        chk("pass_completed", 32'(done_cnt != d0), 1);
        repeat (8) @(negedge i_clk_mhz);
        chk("busy_after_done", 32'(o_busy), 0);
        chk("pass_held", 32'(o_pass), 32'(exp_pass));
    endtask

    task automatic run_pass(input logic [31:0] addr, input logic pass, input int err, input int first);
        int d0;
        setup_pass(addr, pass, err, first);
        d0 = done_cnt;
        do_start();
        wait_done(d0, pass);
    endtask

    initial begin
        int d0;
        int ff_err;
        int ff_first;
        logic [7:0] q;
        i_rstn_mhz = 1'b0; i_start = 1'b0; i_test_address = '0;
        exp_erase_addr = '0; exp_page_addr = '0;
        slow_ce = 1'b0; rand_mode = 1'b0; corrupt = 1'b0; no_store = 1'b0; invert = 1'b0; rd_extra = 0;
        repeat (4) @(negedge i_clk_mhz);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_pass", 32'(o_pass), 0);
        chk("rst_err_count", 32'(o_err_count), 0);
        chk("rst_first_idx", 32'(o_first_err_idx), 32'h1FF);
        chk("rst_wr_valid", 32'(o_wr_data_valid), 0);
        chk("rst_strobes", 32'({o_cmd_erase_subsector, o_cmd_page_program, o_cmd_random_read}), 0);
        i_rstn_mhz = 1'b1;
        repeat (3) @(negedge i_clk_mhz);
        chk("idle_no_start", 32'(o_busy), 0);

        // echo, clean pass
        run_pass(32'h0001_2345, 1'b1, 0, 32'h1FF);

        // two single-bit corruptions on read-back
        corrupt = 1'b1;
        run_pass(32'h0001_2345, 1'b0, 2, 5);
        corrupt = 1'b0;

        // random write backpressure, gappy read stream, surplus read bytes
        rand_mode = 1'b1; rd_extra = 3;
        run_pass(32'h00AB_CDEF, 1'b1, 0, 32'h1FF);
        rand_mode = 1'b0; rd_extra = 0;

        // CE one in four; a second start during programming is ignored
        slow_ce = 1'b1;
        setup_pass(32'h0001_2345, 1'b1, 0, 32'h1FF);
        d0 = done_cnt;
        do_start();
        for (int i = 0; i < 5000 && !o_wr_data_valid; i++) @(negedge i_clk_mhz);
        chk("t4_prog_data_seen", 32'(o_wr_data_valid), 1);
        i_start = 1'b1;
        repeat (8) @(negedge i_clk_mhz);
        i_start = 1'b0;
        wait_done(d0, 1'b1);
        repeat (60) @(negedge i_clk_mhz);
        chk("t4_single_done", done_cnt, d0 + 1);
        slow_ce = 1'b0;

        // reset in the middle of read-back
        setup_pass(32'h0001_2345, 1'b1, 0, 32'h1FF);
        do_start();
        for (int i = 0; i < 5000 && rd_idx < 20; i++) @(negedge i_clk_mhz);
        chk("t5_reading", 32'(rd_idx >= 20), 1);
        i_rstn_mhz = 1'b0;
        #1;
        chk("t5_strobes", 32'({o_cmd_erase_subsector, o_cmd_page_program, o_cmd_random_read}), 0);
        chk("t5_wr_valid", 32'(o_wr_data_valid), 0);
        chk("t5_busy", 32'(o_busy), 0);
        chk("t5_done", 32'(o_done), 0);
        repeat (3) @(negedge i_clk_mhz);
        wr_q.delete();
        res_q.delete();
        i_rstn_mhz = 1'b1;
        repeat (2) @(negedge i_clk_mhz);
        run_pass(32'h0001_2345, 1'b1, 0, 32'h1FF);

        // read-back of erased page only
        ff_err = 0; ff_first = 32'h1FF; q = 8'hA5;
        for (int i = 0; i < 256; i++) begin
            if (q != 8'hFF) begin
                ff_err++;
                if (ff_first == 32'h1FF) ff_first = i;
            end
            q = m_lfsr(q);
        end
        no_store = 1'b1;
        run_pass(32'h0001_2345, 1'(ff_err == 0), ff_err, ff_first);
        no_store = 1'b0;

        // every byte wrong: error count reaches its ceiling
        invert = 1'b1;
        run_pass(32'h0001_2345, 1'b0, 256, 0);
        invert = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
